data_bus_arbiter: RTL and testbench

//  Shares the single-port data memory bus between the pipeline MEM stage (CPU) and a DMA requester (UART loader).
//  CPU has default ownership. DMA is served in idle CPU cycles, or by forced grant once starved.

---
 rtl/data_bus_arbiter_pkg.sv | 24 ++
 rtl/data_bus_arbiter_if.sv | 50 +++++
 rtl/data_bus_arbiter_sat_counter.sv | 22 ++
 rtl/data_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and helpers for the data bus arbiter.
// Perf counter widths apply only when ARB_PERF_CNT_EN is defined.
package data_bus_arb_pkg;

  typedef enum logic {
    S_CPU,
    S_DMA
  } arb_state_e;

  localparam int PERF_W = 16;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// CPU, DMA and memory-side signals of the shared data bus.
// slave = arbiter view, master = surrounding pipeline/DMA/memory view.
interface data_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_wr;
  logic          dma_last;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_wr, dma_last,
    input  dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_wr, dma_last,
    output dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
module arb_sat_counter #(
  parameter int          W   = 4,
  parameter int unsigned MAX = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAXV)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the data memory bus between the MEM stage and a DMA requester.
// ARB_PERF_CNT_EN adds stall/beat performance counters.
module data_bus_arbiter
  import data_bus_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  data_bus_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_dma_beats
`endif
);

  localparam int WW = clog2(MAX_WAIT + 1);
  localparam int BW = clog2(BURST_MAX + 1);

  arb_state_e    state;
  arb_state_e    state_nx;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_nx;

  logic cpu_acc;
  logic wait_full;
  logic gnt;
  logic stall;
  logic use_dma;
  logic cpu_sel;

  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  assign cpu_acc   = bus.cpu_rd | bus.cpu_wr;
  assign wait_full = (wait_cnt == WW'(MAX_WAIT));

  always_comb begin
    gnt      = 1'b0;
    stall    = 1'b0;
    use_dma  = 1'b0;
    cpu_sel  = 1'b0;
    state_nx = state;
    beat_nx  = beat_cnt;
    if (reset) begin
      unique case (state)
        S_CPU: begin
          gnt     = bus.dma_req & (~cpu_acc | wait_full);
          stall   = cpu_acc & gnt;
          use_dma = gnt;
          cpu_sel = ~gnt;
          if (gnt && !bus.dma_last && (BURST_MAX > 1)) begin
            state_nx = S_DMA;
            beat_nx  = BW'(1);
          end
        end
        S_DMA: begin
          gnt     = bus.dma_req;
          stall   = cpu_acc;
          use_dma = bus.dma_req;
          if (!bus.dma_req) begin
            state_nx = S_CPU;
          end else begin
            beat_nx = beat_cnt + 1'b1;
            // lock ends once this beat completes the allowed burst
            if (bus.dma_last ||
                ((beat_cnt + 1'b1) == BW'(BURST_MAX))) begin
              state_nx = S_CPU;
            end
          end
        end
        default: state_nx = S_CPU;
      endcase
    end
  end

  assign addr_mux  = use_dma ? bus.dma_addr : bus.cpu_addr;
  assign wdata_mux = use_dma ? bus.dma_wdata : bus.cpu_wdata;

  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_rd    = use_dma ? ~bus.dma_wr
                                 : (cpu_sel & bus.cpu_rd);
  assign bus.mem_wr    = use_dma ? bus.dma_wr
                                 : (cpu_sel & bus.cpu_wr);
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = stall;
  assign bus.dma_gnt   = gnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_CPU;
      beat_cnt       <= '0;
      bus.dma_rvalid <= 1'b0;
      bus.dma_rdata  <= '0;
    end else begin
      state          <= state_nx;
      beat_cnt       <= beat_nx;
      bus.dma_rvalid <= gnt & ~bus.dma_wr;
      if (gnt && !bus.dma_wr) begin
        bus.dma_rdata <= bus.mem_rdata;
      end
    end
  end

  arb_sat_counter #(
    .W   (WW),
    .MAX (MAX_WAIT)
  ) u_wait (
    .clk (clk),
    .clr (~reset | gnt | ~bus.dma_req),
    .inc (bus.dma_req & ~gnt),
    .cnt (wait_cnt)
  );

`ifdef ARB_PERF_CNT_EN
  arb_sat_counter #(
    .W   (PERF_W),
    .MAX (16'hFFFF)
  ) u_perf_stall (
    .clk (clk),
    .clr (~reset),
    .inc (stall),
    .cnt (perf_stall_cnt)
  );

  arb_sat_counter #(
    .W   (PERF_W),
    .MAX (16'hFFFF)
  ) u_perf_beats (
    .clk (clk),
    .clr (~reset),
    .inc (gnt),
    .cnt (perf_dma_beats)
  );
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter with a DMA read scoreboard.
// Define ARB_PERF_CNT_EN to also exercise the perf counters.
module tb_data_bus_arbiter;
  import data_bus_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_init = 1'b0;

  always #5 clk = ~clk;

  data_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_dma_beats;
`endif

  data_bus_arbiter #(
    .AW        (32),
    .DW        (32),
    .MAX_WAIT  (8),
    .BURST_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_dma_beats (perf_dma_beats)
`endif
  );

  logic [31:0] mem [0:255];

  function automatic logic [31:0] pat(input logic [7:0] i);
    return 32'hA500_0000 ^ {16'h0, i, i};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  always @(negedge clk) begin
    if (bus.dma_rvalid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_rvalid: got rdata %h, required no rvalid",
                 bus.dma_rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.dma_rdata !== sb_exp) begin
          fails++;
          $display("FAIL sb_dma_rdata: got %h, required %h",
                   bus.dma_rdata, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_wr    = 1'b0;
    bus.dma_last  = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic cpu_read_check(input logic [31:0] a,
                                input logic [31:0] e,
                                input string nm);
    @(negedge clk);
    idle();
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = a;
    #1;
    tests++;
    if (bus.cpu_rdata !== e) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, bus.cpu_rdata, e);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    mem_init = 1'b1;
    bus.cpu_rd = 1'b1;
    bus.dma_req = 1'b1;
    bus.dma_wr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({bus.mem_rd, bus.mem_wr, bus.dma_gnt, bus.cpu_stall} !== 4'b0) begin
      fails++;
      $display("FAIL reset_bus: got rd/wr/gnt/stall %b, required 0000",
               {bus.mem_rd, bus.mem_wr, bus.dma_gnt, bus.cpu_stall});
    end
    tests++;
    if ({bus.dma_rvalid, bus.dma_rdata} !== 33'h0) begin
      fails++;
      $display("FAIL reset_dma_out: got rvalid %b rdata %h, required 0/0",
               bus.dma_rvalid, bus.dma_rdata);
    end
    @(negedge clk);
    mem_init = 1'b0;
    reset = 1'b1;
    idle();
  endtask

  task automatic test_cpu_only();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      bus.cpu_rd   = 1'b1;
      bus.cpu_addr = 32'h100 + 32'(i * 4);
      #1;
      tests++;
      if ({bus.cpu_stall, bus.mem_rd, bus.mem_wr} !== 3'b010) begin
        fails++;
        $display("FAIL cpu_only_ctl: got stall/rd/wr %b, required 010",
                 {bus.cpu_stall, bus.mem_rd, bus.mem_wr});
      end
      tests++;
      if (bus.mem_addr !== bus.cpu_addr) begin
        fails++;
        $display("FAIL cpu_only_addr: got %h, required %h",
                 bus.mem_addr, 32'h100 + 32'(i * 4));
      end
      tests++;
      if (bus.cpu_rdata !== pat(8'(8'h40 + i))) begin
        fails++;
        $display("FAIL cpu_only_rdata: got %h, required %h",
                 bus.cpu_rdata, pat(8'(8'h40 + i)));
      end
    end
    @(negedge clk);
    idle();
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 32'h140;
    bus.cpu_wdata = 32'hC0FF_EE01;
    #1;
    tests++;
    if ({bus.cpu_stall, bus.mem_rd, bus.mem_wr} !== 3'b001) begin
      fails++;
      $display("FAIL cpu_write_ctl: got stall/rd/wr %b, required 001",
               {bus.cpu_stall, bus.mem_rd, bus.mem_wr});
    end
    cpu_read_check(32'h140, 32'hC0FF_EE01, "cpu_write_readback");
  endtask

  task automatic test_dma_idle_read();
    @(negedge clk);
    idle();
    bus.dma_req  = 1'b1;
    bus.dma_last = 1'b1;
    bus.dma_addr = 32'h10;
    exp_q.push_back(pat(8'h04));
    #1;
    tests++;
    if ({bus.dma_gnt, bus.cpu_stall, bus.mem_rd, bus.mem_addr} !==
        {1'b1, 1'b0, 1'b1, 32'h10}) begin
      fails++;
      $display("FAIL dma_idle_gnt: got gnt %b stall %b rd %b addr %h, required 1 0 1 00000010",
               bus.dma_gnt, bus.cpu_stall, bus.mem_rd, bus.mem_addr);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL dma_rvalid_latency: got %0d pending, required 0",
               exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.dma_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL dma_rvalid_drop: got %b, required 0", bus.dma_rvalid);
    end
  endtask

  task automatic forced_grant(input int rep, output int gcyc,
                              output int stalls, output logic [33:0] gbus);
    gcyc = 0;
    stalls = 0;
    gbus = '0;
    for (int c = 1; c <= 20 && gcyc == 0; c++) begin
      @(negedge clk);
      bus.cpu_rd    = 1'b1;
      bus.cpu_wr    = 1'b0;
      bus.cpu_addr  = 32'h200;
      bus.dma_req   = 1'b1;
      bus.dma_wr    = 1'b1;
      bus.dma_last  = 1'b1;
      bus.dma_addr  = 32'h300 + 32'(rep * 4);
      bus.dma_wdata = 32'hD000_0000 + 32'(rep);
      #1;
      if (bus.cpu_stall === 1'b1) stalls++;
      if (bus.dma_gnt === 1'b1) begin
        gcyc = c;
        gbus = {bus.mem_rd, bus.mem_wr, bus.mem_addr};
      end
    end
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    if (bus.cpu_stall === 1'b1) stalls++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_forced_grant();
    int gcyc;
    int stalls;
    logic [33:0] gbus;
    forced_grant(0, gcyc, stalls, gbus);
    tests++;
    if (gcyc != 9) begin
      fails++;
      $display("FAIL forced_gnt_cycle: got %0d, required 9", gcyc);
    end
    tests++;
    if (stalls != 1) begin
      fails++;
      $display("FAIL forced_stall_cycles: got %0d, required 1", stalls);
    end
    tests++;
    if (gbus !== {1'b0, 1'b1, 32'h300}) begin
      fails++;
      $display("FAIL forced_bus: got %h, required %h",
               gbus, {1'b0, 1'b1, 32'h300});
    end
    cpu_read_check(32'h300, 32'hD000_0000, "forced_write_data");
    cpu_read_check(32'h200, pat(8'h80), "forced_cpu_addr_intact");
  endtask

  task automatic test_burst();
    int gcyc[6];
    int exp_c[6];
    int b;
    int cyc;
    int stalls;
    exp_c = '{1, 2, 3, 4, 13, 14};
    foreach (gcyc[k]) gcyc[k] = 0;
    b = 0;
    cyc = 0;
    stalls = 0;
    while (b < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.cpu_rd    = (cyc >= 2);
      bus.cpu_addr  = 32'h200;
      bus.dma_req   = 1'b1;
      bus.dma_wr    = 1'b1;
      bus.dma_addr  = 32'h80 + 32'(b * 4);
      bus.dma_wdata = 32'hB000_0000 + 32'(b);
      bus.dma_last  = (b == 5);
      #1;
      if (bus.cpu_stall === 1'b1) stalls++;
      if (bus.dma_gnt === 1'b1) begin
        gcyc[b] = cyc;
        b++;
      end
    end
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    if (bus.cpu_stall === 1'b1) stalls++;
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (gcyc[k] != exp_c[k]) begin
        fails++;
        $display("FAIL burst_beat%0d_cycle: got %0d, required %0d",
                 k + 1, gcyc[k], exp_c[k]);
      end
    end
    tests++;
    if (stalls != 5) begin
      fails++;
      $display("FAIL burst_stalls: got %0d, required 5", stalls);
    end
    for (int k = 0; k < 6; k++) begin
      cpu_read_check(32'h80 + 32'(k * 4), 32'hB000_0000 + 32'(k),
                     "burst_mem_data");
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    idle();
    bus.dma_req   = 1'b1;
    bus.dma_wr    = 1'b1;
    bus.dma_addr  = 32'hC0;
    bus.dma_wdata = 32'hE000_00E0;
    @(negedge clk);
    bus.dma_wr   = 1'b0;
    bus.dma_addr = 32'hC4;
    exp_q.push_back(pat(8'h31));
    @(negedge clk);
    reset = 1'b0;
    bus.dma_wr    = 1'b1;
    bus.dma_addr  = 32'hC8;
    bus.dma_wdata = 32'hEEEE_EEEE;
    #1;
    tests++;
    if ({bus.mem_wr, bus.mem_rd, bus.dma_gnt} !== 3'b000) begin
      fails++;
      $display("FAIL rst_burst_bus: got wr/rd/gnt %b, required 000",
               {bus.mem_wr, bus.mem_rd, bus.dma_gnt});
    end
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h200;
    #1;
    tests++;
    if (bus.dma_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_burst_rvalid: got %b, required 0", bus.dma_rvalid);
    end
    tests++;
    if ({bus.dma_gnt, bus.cpu_stall} !== 2'b00) begin
      fails++;
      $display("FAIL rst_burst_state: got gnt/stall %b, required 00",
               {bus.dma_gnt, bus.cpu_stall});
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_burst_read: got %0d pending, required 0",
               exp_q.size());
      exp_q.delete();
    end
    cpu_read_check(32'hC8, pat(8'h32), "rst_burst_no_write");
    cpu_read_check(32'hC0, 32'hE000_00E0, "rst_burst_beat1");
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    int gcyc;
    int stalls;
    logic [33:0] gbus;
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int r = 4; r < 7; r++) forced_grant(r, gcyc, stalls, gbus);
    tests++;
    if (perf_stall_cnt !== 16'd3) begin
      fails++;
      $display("FAIL perf_stall_cnt: got %0d, required 3", perf_stall_cnt);
    end
    tests++;
    if (perf_dma_beats !== 16'd3) begin
      fails++;
      $display("FAIL perf_dma_beats: got %0d, required 3", perf_dma_beats);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_only();
    test_dma_idle_read();
    test_forced_grant();
    test_burst();
    test_reset_mid_burst();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
